// File: rtl/mouse_packet_decoder.sv
// Assembles 3-byte PS/2 movement packets into buttons, deltas and a clamped cursor.
// Define MOUSE_OVF_DISCARD_EN to drop packets whose header carries an overflow flag.
module mouse_packet_decoder #(
    parameter int unsigned X_MAX          = 639,
    parameter int unsigned Y_MAX          = 479,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic       pkt_valid,
    output logic [2:0] buttons,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic       x_ovf,
    output logic       y_ovf,
    output logic [9:0] cursor_x,
    output logic [9:0] cursor_y,
    output logic       sync_err
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [9:0] X_MAX10 = 10'(X_MAX);
    localparam logic [9:0] Y_MAX10 = 10'(Y_MAX);
    localparam logic signed [10:0] X_LIM = 11'(X_MAX);
    localparam logic signed [10:0] Y_LIM = 11'(Y_MAX);
    localparam logic [9:0] X_RST = 10'((X_MAX + 1) / 2);
    localparam logic [9:0] Y_RST = 10'((Y_MAX + 1) / 2);

    typedef enum logic [1:0] {StB0, StB1, StB2} state_e;

    state_e        state_q, state_d, cur_state;
    logic [CW-1:0] cnt_q, cnt_d;
    // Header without the always-one sync bit: {y_ovf, x_ovf, y_sign, x_sign, btn[2:0]}
    logic [6:0]    hdr_q, hdr_d;
    logic [7:0]    xb_q, xb_d;
    logic          pkt_q, pkt_d, err_q, err_d;
    logic [2:0]    buttons_q, buttons_d;
    logic [8:0]    dx_q, dx_d, dy_q, dy_d;
    logic          xo_q, xo_d, yo_q, yo_d;
    logic [9:0]    cx_q, cx_d, cy_q, cy_d;

    logic                expire, pkt_done, ovf_drop;
    logic [8:0]          new_dx, new_dy;
    logic signed [10:0]  x_sum, y_sum;
    logic [9:0]          x_clamp, y_clamp;

    assign new_dx = {hdr_q[3], xb_q};
    assign new_dy = {hdr_q[4], rx_byte};
    assign x_sum  = $signed({1'b0, cx_q}) + $signed({{2{new_dx[8]}}, new_dx});
    assign y_sum  = $signed({1'b0, cy_q}) - $signed({{2{new_dy[8]}}, new_dy});

`ifdef MOUSE_OVF_DISCARD_EN
    assign ovf_drop = hdr_q[5] | hdr_q[6];
`else
    assign ovf_drop = 1'b0;
`endif

    always_comb begin
        x_clamp = x_sum[9:0];
        if (x_sum < 0)          x_clamp = '0;
        else if (x_sum > X_LIM) x_clamp = X_MAX10;
        y_clamp = y_sum[9:0];
        if (y_sum < 0)          y_clamp = '0;
        else if (y_sum > Y_LIM) y_clamp = Y_MAX10;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hdr_d     = hdr_q;
        xb_d      = xb_q;
        pkt_d     = 1'b0;
        err_d     = 1'b0;
        buttons_d = buttons_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        xo_d      = xo_q;
        yo_d      = yo_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        expire    = 1'b0;
        pkt_done  = 1'b0;
        cur_state = state_q;

        if (!enable) begin
            state_d = StB0;
            cnt_d   = '0;
        end else begin
            expire = (state_q != StB0) && (cnt_q == TO_LIMIT);
            // A byte arriving on the expiry cycle is judged as a fresh header.
            if (expire) begin
                cur_state = StB0;
                state_d   = StB0;
                cnt_d     = '0;
                err_d     = 1'b1;
            end else if (state_q != StB0) begin
                cnt_d = cnt_q + 1'b1;
            end

            if (rx_valid) begin
                cnt_d = '0;
                case (cur_state)
                    StB0: begin
                        if (rx_byte[3]) begin
                            hdr_d   = {rx_byte[7:4], rx_byte[2:0]};
                            state_d = StB1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    StB1: begin
                        xb_d    = rx_byte;
                        state_d = StB2;
                    end
                    StB2: begin
                        state_d  = StB0;
                        pkt_done = 1'b1;
                    end
                    default: state_d = StB0;
                endcase
            end

            if (pkt_done) begin
                if (ovf_drop) begin
                    err_d = 1'b1;
                end else begin
                    pkt_d     = 1'b1;
                    buttons_d = hdr_q[2:0];
                    dx_d      = new_dx;
                    dy_d      = new_dy;
                    xo_d      = hdr_q[5];
                    yo_d      = hdr_q[6];
                    cx_d      = x_clamp;
                    cy_d      = y_clamp;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StB0;
            cnt_q     <= '0;
            hdr_q     <= '0;
            xb_q      <= '0;
            pkt_q     <= 1'b0;
            err_q     <= 1'b0;
            buttons_q <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            xo_q      <= 1'b0;
            yo_q      <= 1'b0;
            cx_q      <= X_RST;
            cy_q      <= Y_RST;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hdr_q     <= hdr_d;
            xb_q      <= xb_d;
            pkt_q     <= pkt_d;
            err_q     <= err_d;
            buttons_q <= buttons_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            xo_q      <= xo_d;
            yo_q      <= yo_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
        end
    end

    assign pkt_valid = pkt_q;
    assign sync_err  = err_q;
    assign buttons   = buttons_q;
    assign dx        = dx_q;
    assign dy        = dy_q;
    assign x_ovf     = xo_q;
    assign y_ovf     = yo_q;
    assign cursor_x  = cx_q;
    assign cursor_y  = cy_q;

endmodule

// File: tb/tb_mouse_packet_decoder.sv
// Scoreboard bench for mouse_packet_decoder: directed packets plus randomized byte streams.
module tb_mouse_packet_decoder;

    localparam int X_MAX = 639;
    localparam int Y_MAX = 479;
    localparam int TO    = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic       pkt_valid, x_ovf, y_ovf, sync_err;
    logic [2:0] buttons;
    logic [8:0] dx, dy;
    logic [9:0] cursor_x, cursor_y;

    mouse_packet_decoder #(
        .X_MAX(X_MAX),
        .Y_MAX(Y_MAX),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .rx_byte(rx_byte),
        .rx_valid(rx_valid),
        .pkt_valid(pkt_valid),
        .buttons(buttons),
        .dx(dx),
        .dy(dy),
        .x_ovf(x_ovf),
        .y_ovf(y_ovf),
        .cursor_x(cursor_x),
        .cursor_y(cursor_y),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       is_pkt;
        bit [2:0] btn;
        int       dx;
        int       dy;
        bit       xo;
        bit       yo;
        int       cx;
        int       cy;
    } exp_t;

    exp_t     expq[$];
    bit [7:0] pend[$];
    int       idle;
    bit [2:0] m_btn;
    int       m_dx, m_dy, m_cx, m_cy;
    bit       m_xo, m_yo;
    int       checks = 0;
    int       failures = 0;

    function automatic int clamp(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic void push_evt(bit is_pkt);
        exp_t e;
        e.is_pkt = is_pkt;
        e.btn = m_btn; e.dx = m_dx; e.dy = m_dy;
        e.xo = m_xo; e.yo = m_yo; e.cx = m_cx; e.cy = m_cy;
        expq.push_back(e);
    endfunction

    function automatic void model_reset();
        pend.delete();
        idle = 0;
        m_btn = 3'b000; m_dx = 0; m_dy = 0; m_xo = 0; m_yo = 0;
        m_cx = (X_MAX + 1) / 2;
        m_cy = (Y_MAX + 1) / 2;
    endfunction

    function automatic void finish_pkt();
        bit [7:0] b0, b1, b2;
        b0 = pend[0]; b1 = pend[1]; b2 = pend[2];
`ifdef MOUSE_OVF_DISCARD_EN
        if (b0[6] || b0[7]) begin
            push_evt(1'b0);
            return;
        end
`endif
        m_btn = b0[2:0];
        m_dx  = int'(b1) - (b0[4] ? 256 : 0);
        m_dy  = int'(b2) - (b0[5] ? 256 : 0);
        m_xo  = b0[6];
        m_yo  = b0[7];
        m_cx  = clamp(m_cx + m_dx, 0, X_MAX);
        m_cy  = clamp(m_cy - m_dy, 0, Y_MAX);
        push_evt(1'b1);
    endfunction

    // One clock cycle of behaviour for the inputs presented before the next edge.
    function automatic void model_step(bit r, bit e, bit v, bit [7:0] b);
        bit to;
        if (r) begin model_reset(); return; end
        if (!e) begin pend.delete(); idle = 0; return; end
        to = (pend.size() != 0) && (idle == TO);
        if (to) begin
            push_evt(1'b0);
            pend.delete();
            idle = 0;
        end else if (pend.size() != 0) begin
            idle++;
        end
        if (v) begin
            idle = 0;
            if (pend.size() == 0) begin
                if (b[3]) pend.push_back(b);
                else if (!to) push_evt(1'b0);
            end else begin
                pend.push_back(b);
                if (pend.size() == 3) begin
                    finish_pkt();
                    pend.delete();
                end
            end
        end
    endfunction

    task automatic cmp(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(bit r, bit e, bit v, bit [7:0] b);
        rst = r; enable = e; rx_valid = v; rx_byte = b;
        model_step(r, e, v, b);
        @(posedge clk);
        #2;
    endtask

    task automatic send(bit [7:0] b);
        step(1'b0, 1'b1, 1'b1, b);
    endtask

    task automatic idle_n(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_reset_vals(string tag);
        cmp({tag, "_pkt_valid"}, int'(pkt_valid), 0);
        cmp({tag, "_sync_err"}, int'(sync_err), 0);
        cmp({tag, "_buttons"}, int'(buttons), 0);
        cmp({tag, "_dx"}, int'(dx), 0);
        cmp({tag, "_dy"}, int'(dy), 0);
        cmp({tag, "_ovf"}, int'({x_ovf, y_ovf}), 0);
        cmp({tag, "_cursor_x"}, int'(cursor_x), 320);
        cmp({tag, "_cursor_y"}, int'(cursor_y), 240);
    endtask

    // Monitor: every strobe must match the oldest expectation, one per cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() != 0) begin
                exp_t e;
                e = expq.pop_front();
                cmp("pkt_valid", int'(pkt_valid), int'(e.is_pkt));
                cmp("sync_err", int'(sync_err), int'(!e.is_pkt));
                if (e.is_pkt) begin
                    cmp("buttons", int'(buttons), int'(e.btn));
                    cmp("dx", int'($signed(dx)), e.dx);
                    cmp("dy", int'($signed(dy)), e.dy);
                    cmp("x_ovf", int'(x_ovf), int'(e.xo));
                    cmp("y_ovf", int'(y_ovf), int'(e.yo));
                end
                cmp("cursor_x", int'(cursor_x), e.cx);
                cmp("cursor_y", int'(cursor_y), e.cy);
            end else if (pkt_valid || sync_err) begin
                cmp("spurious_strobe", int'({pkt_valid, sync_err}), 0);
            end
        end
    end

    initial begin
        model_reset();
        do_reset();
        check_reset_vals("reset");

        // Basic packet
        send(8'h08); send(8'h05); send(8'h03);
        cmp("tp1_cursor_x", int'(cursor_x), 325);
        cmp("tp1_cursor_y", int'(cursor_y), 237);
        idle_n(2);

        // Negative deltas with left button
        do_reset();
        send(8'h39); send(8'hF6); send(8'hFE);
        cmp("tp2_dx", int'($signed(dx)), -10);
        cmp("tp2_dy", int'($signed(dy)), -2);
        cmp("tp2_buttons", int'(buttons), 1);
        cmp("tp2_cursor_x", int'(cursor_x), 310);
        cmp("tp2_cursor_y", int'(cursor_y), 242);
        idle_n(2);

        // Bad header then a good packet
        send(8'h00); send(8'h08); send(8'h01); send(8'h01);
        idle_n(2);

        // Partial packet abandoned by timeout
        send(8'h08); send(8'h10);
        idle_n(TO + 3);
        send(8'h08); send(8'h02); send(8'h02);
        cmp("tp4_dx", int'($signed(dx)), 2);
        idle_n(2);

        // Saturation at right edge, then top edge
        do_reset();
        for (int i = 0; i < 20; i++) begin send(8'h08); send(8'h64); send(8'h00); end
        cmp("tp5_cursor_x_sat", int'(cursor_x), X_MAX);
        do_reset();
        for (int i = 0; i < 20; i++) begin send(8'h08); send(8'h00); send(8'h64); end
        cmp("tp5_cursor_y_sat", int'(cursor_y), 0);
        idle_n(2);

        // Overflow header
        do_reset();
        send(8'h48); send(8'h10); send(8'h00);
`ifdef MOUSE_OVF_DISCARD_EN
        cmp("tp6_cursor_x_hold", int'(cursor_x), 320);
`else
        cmp("tp6_x_ovf", int'(x_ovf), 1);
        cmp("tp6_dx", int'($signed(dx)), 16);
`endif
        idle_n(2);

        // Reset mid-packet
        do_reset();
        send(8'h08); send(8'h05);
        do_reset();
        check_reset_vals("midrst");
        idle_n(3);

        // Randomized streams with gaps, enable drops and occasional reset
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            bit [7:0] b;
            r = $urandom_range(0, 999);
            if (r < 3) begin
                step(1'b1, 1'b1, 1'b0, 8'h00);
            end else if (r < 13) begin
                for (int k = 0; k < 3; k++)
                    step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            end else if (r < 30) begin
                idle_n(int'($urandom_range(TO - 2, TO + 2)));
            end else begin
                b = 8'($urandom);
                if ($urandom_range(0, 9) < 8) b[3] = 1'b1;
                if ($urandom_range(0, 9) < 8) b[7:6] = 2'b00;
                step(1'b0, 1'b1, 1'($urandom_range(0, 9) < 6), b);
            end
        end
        idle_n(4);
        cmp("queue_drained", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mouse_packet_decoder.md
# mouse_packet_decoder

Downstream stage of the PS/2 mouse controller. It consumes the byte stream the controller receives after mouse setup completes and assembles standard 3-byte PS/2 movement packets. It outputs decoded buttons and signed deltas with a one-cycle packet strobe, and maintains a clamped screen cursor position. Outputs feed the display and debug hex path in place of raw byte registers.

## Interface
- X_MAX, 639, largest cursor_x value
- Y_MAX, 479, largest cursor_y value
- TIMEOUT_CYCLES, 100000, idle clk cycles between packet bytes before resync (2 ms at 50 MHz)
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  high once controller setup (reset, enable, ack) is done; low = ignore bytes
- rx_byte  in  8  byte received from mouse
- rx_valid  in  1  one-cycle strobe, rx_byte valid
- pkt_valid  out  1  one-cycle strobe, packet fields updated
- buttons  out  3  {middle, right, left} from byte0[2:0]
- dx  out  9  signed X delta {byte0[4], byte1}
- dy  out  9  signed Y delta {byte0[5], byte2}, positive = up
- x_ovf, y_ovf  out  1 each  byte0[6], byte0[7] of last packet
- cursor_x  out  10  cursor column, 0..X_MAX
- cursor_y  out  10  cursor row, 0..Y_MAX, 0 = top
- sync_err  out  1  one-cycle strobe, byte0 rejected or timeout

## Operation
- States: B0 (await header), B1 (await X byte), B2 (await Y byte).
- B0 + rx_valid: if rx_byte[3]=1, latch header, go B1. Otherwise drop the byte, pulse sync_err, and stay in B0.
- B1 + rx_valid: latch X byte, go B2.
- B2 + rx_valid: latch Y byte, go B0. Next cycle: update all packet outputs, pulse pkt_valid, update cursor.
- Timeout counter clears on every accepted byte and counts while in B1/B2.
  - On reaching TIMEOUT_CYCLES: return to B0 and pulse sync_err.
  - If rx_valid coincides with expiry, the byte is evaluated as a B0 header in that same cycle.
- enable low: state forced to B0, counter cleared, rx_valid ignored. Outputs and cursor hold.
- Cursor arithmetic uses 11-bit signed intermediates:
  - cursor_x += dx, clamped to [0, X_MAX].
  - cursor_y -= dy, clamped to [0, Y_MAX].
  - Clamping is saturating, never wrapping.
- Reset values:
  - pkt_valid = 0, sync_err = 0.
  - buttons = 0, dx = 0, dy = 0, x_ovf = 0, y_ovf = 0.
  - cursor_x = (X_MAX+1)/2 (320), cursor_y = (Y_MAX+1)/2 (240).
  - state = B0, counter = 0.
- rst mid-packet discards partial bytes. No pkt_valid is generated for the partial packet.

## Timing
- Latency: pkt_valid asserts exactly 1 cycle after the rx_valid of byte 2. Packet fields and cursor change on that same edge.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Back-to-back rx_valid on consecutive cycles is accepted, one byte per cycle.
- The block has no backpressure. The consumer must sample on pkt_valid.
- sync_err and pkt_valid never assert in the same cycle.

## Configuration
- MOUSE_OVF_DISCARD_EN defined:
  - A completed packet with byte0[6] or byte0[7] set is discarded.
  - No pkt_valid pulses, and buttons, deltas, ovf flags and cursor hold.
  - sync_err pulses 1 cycle after byte 2.
- Not defined: overflow packets are applied normally, with ovf flags reported.

## Test plan
- Reset, enable=1, bytes 0x08, 0x05, 0x03 → pkt_valid 1 cycle after third byte; dx=+5, dy=+3, buttons=0; cursor (325, 237).
- Header 0x39 (left button, X and Y sign), bytes 0xF6, 0xFE → dx=-10, dy=-2, buttons=3'b001; cursor from (320, 240) moves to (310, 242).
- Stream 0x00 then 0x08, 0x01, 0x01 → sync_err pulse on 0x00; one packet decoded from remaining bytes, dx=+1, dy=+1.
- 0x08, 0x10, then silence of TIMEOUT_CYCLES → sync_err; following 0x08, 0x02, 0x02 decodes as a clean packet (dx=+2, dy=+2).
- Twenty packets of dx=+100 → cursor_x saturates at 639 and never wraps; same check for dy=+100 leaving cursor_y at 0.
- Header 0x48 (X overflow), 0x10, 0x00: with MOUSE_OVF_DISCARD_EN → no pkt_valid, sync_err pulse, cursor unchanged; without → pkt_valid, x_ovf=1, dx=+16. Also assert rst after byte 1 → no pkt_valid, outputs at reset values.
